// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with credit-limited prefetch buffer and redirect drain
// Optional macro FETCH_MISALIGN_CHECK_EN: ignore misaligned redirects and raise sticky misalign_err.
module instr_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BUF_DEPTH  = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [6:0]            op,
    output logic [2:0]            funct3,
    output logic                  funct7_5,
    output logic                  misalign_err
);

    localparam int              PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int              CW      = PW + 1;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(BUF_DEPTH);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         outst_q, outst_d;
    logic [CW-1:0]         stale_q, stale_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;

    logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc   [BUF_DEPTH];

    logic                  req_fire;
    logic                  rsp_fire;
    logic                  pop;
    logic                  push;
    logic                  redir_acc;
    logic [ADDR_WIDTH-1:0] redir_pc;
    logic [CW:0]           credit_used;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign redir_acc    = redirect_valid & (redirect_target[1:0] == 2'b00);
    assign redir_pc     = redirect_target;
    assign misalign_err = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end
`else
    logic unused_target_lsb;

    assign unused_target_lsb = ^redirect_target[1:0];
    assign redir_acc         = redirect_valid;
    assign redir_pc          = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
    assign misalign_err      = 1'b0;
`endif

    // Credit covers in-flight requests too, so every response has a guaranteed slot.
    assign credit_used    = {1'b0, outst_q} + {1'b0, count_q};
    assign imem_req_valid = rst_n & (state_q == RUN) & (credit_used < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_fire       = imem_rsp_valid & (outst_q != '0);
    assign push           = rsp_fire & (state_q == RUN) & ~redir_acc;

    assign instr_valid    = (count_q != '0);
    assign pop            = instr_valid & instr_ready;
    assign instr          = buf_data[rd_ptr_q];
    assign instr_pc       = buf_pc[rd_ptr_q];
    assign op             = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7_5       = instr[30];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q + CW'(req_fire) - CW'(rsp_fire);
        stale_d  = stale_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (req_fire) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(4);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case (state_q)
            RUN: begin
                // Everything still in flight after this edge belongs to the old stream.
                if (redir_acc) begin
                    stale_d = outst_d;
                    if (outst_d != '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (rsp_fire && (stale_q != '0)) begin
                    stale_d = stale_q - CW'(1);
                end
                if ((stale_d == '0) && !redir_acc) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (redir_acc) begin
            pc_d     = redir_pc;
            rsp_pc_d = redir_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            stale_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            stale_q  <= stale_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr_q] <= imem_rsp_data;
            buf_pc[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule
